// File: rtl/dec_ptv_pipe.sv
// Pipelined SCB tree walk: translates a physical page address to a virtual one, one level per stage.
// Optional perf counters are built when PTV_PERF_CNT_EN is defined.

// One tree level: picks the SCB bit of the active node and activates the child chosen by i_dir.
module dec_ptv_stage #(
  parameter int unsigned NODES = 64
) (
  input  logic [NODES-1:0] i_actv,
  input  logic             i_dir,
  input  logic [NODES-1:0] i_scb,
  output logic [NODES-1:0] o_actv,
  output logic             o_scb
);

  always_comb begin
    o_scb  = |(i_actv & i_scb);
    o_actv = '0;
    // Node n at this level feeds children 2n and 2n+1 at the next level.
    for (int unsigned n = 0; n < NODES; n++) begin
      o_actv[n] = i_actv[n/2] & (n[0] == i_dir);
    end
  end

endmodule

module dec_ptv_pipe #(
  parameter  int unsigned BITMAP = 128,
  localparam int unsigned STAGES = $clog2(BITMAP),
  localparam int unsigned NODES  = BITMAP / 2,
  localparam int unsigned ADDR_W = STAGES
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [STAGES*NODES-1:0] i_scb,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [ADDR_W-1:0]       i_paddr,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ADDR_W-1:0]       o_vaddr,
  output logic [ADDR_W-1:0]       o_paddr,
  output logic [31:0]             o_xlt_cnt,
  output logic [31:0]             o_stl_cnt
);

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] rdy;

  // A slot may load if it or any slot downstream of it is empty, or the consumer takes the output.
  always_comb begin
    rdy = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      logic full;
      full = 1'b1;
      for (int unsigned t = s; t < STAGES; t++) begin
        full = full & v_all[t];
      end
      rdy[s] = i_ready | ~full;
    end
  end

  assign o_ready = rdy[0] & ~i_flush;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic              v_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [NODES-1:0]  actv_q;
    logic [ADDR_W-1:0] vaddr_q;
    logic [ADDR_W-1:0] vaddr_d;
    logic [NODES-1:0]  actv_in;
    logic [NODES-1:0]  actv_out;
    logic              scb_bit;
    logic              src_v;
    logic [ADDR_W-1:0] src_paddr;
    logic [ADDR_W-1:0] src_vaddr;

    if (s == 0) begin : g_root
      assign actv_in   = NODES'(1);
      assign src_v     = i_valid;
      assign src_paddr = i_paddr;
      assign src_vaddr = '0;
    end else begin : g_inner
      assign actv_in   = g_stage[s-1].actv_q;
      assign src_v     = g_stage[s-1].v_q;
      assign src_paddr = g_stage[s-1].paddr_q;
      assign src_vaddr = g_stage[s-1].vaddr_q;
    end

    dec_ptv_stage #(
      .NODES(NODES)
    ) u_stage (
      .i_actv(actv_in),
      .i_dir (src_paddr[ADDR_W-1-s]),
      .i_scb (i_scb[s*NODES +: NODES]),
      .o_actv(actv_out),
      .o_scb (scb_bit)
    );

    always_comb begin
      vaddr_d    = src_vaddr;
      vaddr_d[s] = scb_bit;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        v_q     <= 1'b0;
        paddr_q <= '0;
        actv_q  <= '0;
        vaddr_q <= '0;
      end else if (i_flush) begin
        v_q <= 1'b0;
      end else if (rdy[s]) begin
        v_q <= src_v;
        if (src_v) begin
          paddr_q <= src_paddr;
          actv_q  <= actv_out;
          vaddr_q <= vaddr_d;
        end
      end
    end

    assign v_all[s] = v_q;

    if (s == STAGES - 1) begin : g_last
      logic unused_actv;
      assign unused_actv = ^actv_q;
    end
  end

  assign o_valid = g_stage[STAGES-1].v_q;
  assign o_vaddr = g_stage[STAGES-1].vaddr_q;
  assign o_paddr = g_stage[STAGES-1].paddr_q;

`ifdef PTV_PERF_CNT_EN
  logic [31:0] xlt_cnt_q;
  logic [31:0] stl_cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      xlt_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      if (o_valid && i_ready && !i_flush) begin
        xlt_cnt_q <= xlt_cnt_q + 32'd1;
      end
      if (o_valid && !i_ready) begin
        stl_cnt_q <= stl_cnt_q + 32'd1;
      end
    end
  end

  assign o_xlt_cnt = xlt_cnt_q;
  assign o_stl_cnt = stl_cnt_q;
`else
  assign o_xlt_cnt = '0;
  assign o_stl_cnt = '0;
`endif

endmodule
